// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready streams into one registered output stage.
// Optional packet lock (grants held until in_last) is enabled by defining ARB_LOCK_EN.
module rr_stream_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  logic [SRC_W-1:0]      ptr;
  logic [SRC_W-1:0]      win;
  logic [SRC_W:0]        idx;
  logic                  found;
  logic                  load_ok;
  logic                  accept;
  logic [DATA_WIDTH-1:0] win_data;

`ifdef ARB_LOCK_EN
  logic                  lock_active;
  logic [SRC_W-1:0]      lock_src;
  logic                  win_last;
`else
  logic                  unused_last;
  assign unused_last = ^in_last;
`endif

  // Reset gates readiness so no requester sees a handshake while the block is held in reset.
  assign load_ok = rst_n && (!out_valid || out_ready);
  assign accept  = found && load_ok;

  // Circular search from ptr; idx is one bit wider so ptr+k never overflows before the wrap.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (SRC_W+1)'(k);
      if (idx >= (SRC_W+1)'(NUM_REQ)) idx = idx - (SRC_W+1)'(NUM_REQ);
      if (!found && in_valid[idx[SRC_W-1:0]]) begin
        found = 1'b1;
        win   = idx[SRC_W-1:0];
      end
    end
`ifdef ARB_LOCK_EN
    if (lock_active) begin
      win   = lock_src;
      found = in_valid[lock_src];
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    win_data = '0;
`ifdef ARB_LOCK_EN
    win_last = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == SRC_W'(i)) begin
        in_ready[i] = accept;
        win_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef ARB_LOCK_EN
        win_last    = in_last[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_src   <= win;
      ptr       <= (win == SRC_W'(NUM_REQ-1)) ? '0 : win + SRC_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_LOCK_EN
  // A non-final beat pins arbitration to its source until that source sends in_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_active <= 1'b0;
      lock_src    <= '0;
      out_last    <= 1'b0;
    end else if (accept) begin
      out_last    <= win_last;
      lock_active <= !win_last;
      if (!win_last) lock_src <= win;
    end
  end
`else
  assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Randomized self-checking bench for rr_stream_arbiter with a queue-free behavioural model.
// Also covers NUM_REQ=3 wrap, async reset and (when ARB_LOCK_EN is defined) packet lock.
module tb_rr_stream_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid, in_last, in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_last, out_valid, out_ready;

  logic [95:0]  in_data3;
  logic [2:0]   in_valid3, in_last3, in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_src3;
  logic         out_last3, out_valid3, out_ready3;

  always #5 clk = ~clk;

  rr_stream_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  rr_stream_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
    .in_ready(in_ready3), .out_data(out_data3), .out_src(out_src3), .out_last(out_last3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the output register should hold and whose turn it is.
  int          m_ptr;
  bit          m_lock;
  int          m_lsrc;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_src;
  bit          m_last;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelWinner(input logic [3:0] v);
`ifdef ARB_LOCK_EN
    if (m_lock) return v[m_lsrc] ? m_lsrc : -1;
`endif
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_ptr = 0; m_lock = 0; m_lsrc = 0;
    m_valid = 0; m_data = 0; m_src = 0; m_last = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
    in_valid3 = '0; in_data3 = '0; in_last3 = '0; out_ready3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    modelReset();
  endtask

  // One cycle: drive, check the combinational grant, clock, advance the model, check outputs.
  task automatic applyStimulus(input logic [3:0] v, input logic [127:0] d,
                               input logic [3:0] l, input logic r);
    int w;
    bit ld;
    logic [3:0] exp_ready;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    w  = modelWinner(v);
    ld = !m_valid || r;
    exp_ready = (w >= 0 && ld) ? 4'(1 << w) : 4'b0;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    if (w >= 0 && ld) begin
      m_valid = 1;
      m_data  = d[w*32 +: 32];
      m_src   = w;
`ifdef ARB_LOCK_EN
      m_last  = l[w];
      if (!l[w]) begin m_lock = 1; m_lsrc = w; end
      else m_lock = 0;
`else
      m_last  = 0;
`endif
      m_ptr   = (w + 1) % 4;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      checkOutput("out_data", out_data, m_data);
      checkOutput("out_src", 32'(out_src), 32'(m_src));
    end
    checkOutput("out_last", 32'(out_last), 32'(m_last));
  endtask

  function automatic logic [127:0] rndData();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [127:0] d;
    doReset();
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_out_src", 32'(out_src), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h0);

    // Single requester 2.
    d = '0;
    d[64 +: 32] = 32'hA5A5_0002;
    applyStimulus(4'b0100, d, 4'b1111, 1'b1);
    checkOutput("single_data", out_data, 32'hA5A5_0002);
    checkOutput("single_src", 32'(out_src), 32'd2);
    applyStimulus(4'b0000, d, 4'b1111, 1'b1);

    // Fairness with all valid, starting from ptr 0.
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, rndData(), 4'b1111, 1'b1);
      checkOutput("fair_src", 32'(out_src), 32'(k % 4));
      checkOutput("fair_valid", 32'(out_valid), 32'h1);
    end

    // Backpressure: output full, stalled three cycles, then released.
    doReset();
    applyStimulus(4'b0001, rndData(), 4'b1111, 1'b0);
    d = out_data;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0011, rndData(), 4'b1111, 1'b0);
      checkOutput("stall_data", out_data, d);
    end
    applyStimulus(4'b0011, rndData(), 4'b1111, 1'b1);
    checkOutput("release_src", 32'(out_src), 32'd1);

`ifdef ARB_LOCK_EN
    // Three-beat packet from requester 1 while requester 2 waits.
    doReset();
    applyStimulus(4'b0110, rndData(), 4'b0100, 1'b1);
    checkOutput("lock_src0", 32'(out_src), 32'd1);
    applyStimulus(4'b0110, rndData(), 4'b0100, 1'b1);
    checkOutput("lock_src1", 32'(out_src), 32'd1);
    applyStimulus(4'b0110, rndData(), 4'b0110, 1'b1);
    checkOutput("lock_src2", 32'(out_src), 32'd1);
    applyStimulus(4'b0100, rndData(), 4'b0100, 1'b1);
    checkOutput("lock_src3", 32'(out_src), 32'd2);
`endif

    // NUM_REQ=3 wrap: sources 0,1,2,0,1,2.
    doReset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid3 = 3'b111; in_last3 = 3'b111; out_ready3 = 1'b1;
      in_data3 = {32'd3, 32'd2, 32'd1};
      @(posedge clk);
      #1;
      checkOutput("n3_src", 32'(out_src3), 32'(k % 3));
      checkOutput("n3_data", out_data3, 32'((k % 3) + 1));
`ifdef ARB_LOCK_EN
      checkOutput("n3_last", 32'(out_last3), 32'h1);
`else
      checkOutput("n3_last", 32'(out_last3), 32'h0);
`endif
    end

    // Asynchronous reset with a beat in flight.
    doReset();
    applyStimulus(4'b0010, 128'h0000_0000_0000_0000_1234_5678_0000_0000, 4'b1111, 1'b0);
    @(negedge clk);
    in_valid = 4'b1000; out_ready = 1'b1;
    #2;
    checkOutput("pre_rst_in_ready", 32'(in_ready), 32'h8);
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'h0);
    checkOutput("async_out_data", out_data, 32'h0);
    checkOutput("async_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    modelReset();
    applyStimulus(4'b1111, rndData(), 4'b1111, 1'b1);
    checkOutput("post_rst_src", 32'(out_src), 32'h0);

    // Randomized traffic against the model.
    doReset();
    for (int k = 0; k < 400; k++) begin
      applyStimulus(4'($urandom), rndData(), 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

Round-robin arbiter that shares one registered valid/ready output stage between `NUM_REQ` streaming requesters. It merges several producer streams onto a single downstream pipeline. Each accepted beat is captured into a one-entry output register, which gives one cycle of latency and full throughput. The register also carries the index of the requester that won.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..16, power of two not required.
- `DATA_WIDTH`, 32: payload width per requester.
- `SRC_W`, `$clog2(NUM_REQ)`: derived; width of the source index.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  `NUM_REQ*DATA_WIDTH`: requester payloads; requester i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_valid`  in  `NUM_REQ`: per-requester valid.
- `in_last`  in  `NUM_REQ`: per-requester end-of-packet flag. Used only when `ARB_LOCK_EN` is defined.
- `in_ready`  out  `NUM_REQ`: per-requester ready; at most one bit is high in any cycle.
- `out_data`  out  `DATA_WIDTH`: registered payload.
- `out_src`  out  `SRC_W`: registered index of the winning requester.
- `out_last`  out  1: registered copy of the winner's `in_last`. Driven 0 when `ARB_LOCK_EN` is not defined.
- `out_valid`  out  1: output register holds a beat.
- `out_ready`  in  1: downstream accepts.

## Operation
- State:
  - output register `{out_data, out_src, out_last, out_valid}`;
  - priority pointer `ptr` (`SRC_W` bits);
  - lock state (`lock_active`, `lock_src`), present only with `ARB_LOCK_EN`.
- `load_ok = !out_valid || out_ready`. The output register may load in the same cycle it drains.
- Grant is combinational:
  - Search `in_valid` starting at index `ptr` and increasing, wrapping from `NUM_REQ-1` to 0.
  - The first set bit is the winner.
  - `in_ready[w] = load_ok` for the winner w; all other bits are 0.
  - With no valid requester, all `in_ready` bits are 0.
- Accept means `in_valid[w] && in_ready[w]`. On an accept:
  - `out_data <= in_data[w]`, `out_src <= w`, `out_valid <= 1`;
  - `ptr <= (w == NUM_REQ-1) ? 0 : w+1`, a modulo wrap that is correct for non-power-of-two `NUM_REQ`.
- If there is no accept and `out_valid && out_ready`, then `out_valid <= 0`. The data and src registers hold their values.
- `ptr` advances only on an accept. A requester that deasserts valid before being granted forfeits its turn with no penalty.
- Requesters must hold `in_data` stable while valid and not ready. The block does not check this.

## Timing
- Reset values (asynchronous assert): `out_valid=0`, `out_data=0`, `out_src=0`, `out_last=0`, `ptr=0`, `lock_active=0`, `lock_src=0`.
- Latency: a beat accepted at edge N is visible on `out_*` after edge N.
- Throughput: 1 beat/cycle while `out_ready=1`.
- Backpressure:
  - When `out_valid=1` and `out_ready=0`, all `in_ready` bits are 0 and the output holds.
  - `in_ready` depends combinationally on `out_ready` and `in_valid`. There is no combinational path from `in_data` to any output.
- Simultaneous drain and load in one cycle: `out_valid` stays 1 and the new beat replaces the old one, with no bubble.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0. This holds unless `ARB_LOCK_EN` is defined, in which case grants are per packet.
- Reset mid-transfer: all state clears immediately and the in-flight beat is dropped. After `rst_n` releases, the first grant goes to the lowest valid index.

## Configuration
- Macro `ARB_LOCK_EN` enables packet lock.
- Defined:
  - An accept with `in_last[w]=0` sets `lock_active=1` and `lock_src=w`.
  - While `lock_active=1`, only `lock_src` can be granted. Other requesters wait even if `lock_src` is not valid.
  - An accept with `in_last=1` clears `lock_active`. `ptr` advances on every accept as usual.
  - `out_last` is registered from the winner's `in_last`.
  - A single-beat packet (`in_last=1` on its first beat) never sets the lock.
- Not defined: `in_last` is ignored, `out_last` is tied to 0, no lock state exists, and arbitration is per beat.

## Test plan
- Reset, then `in_valid=4'b0100` with `in_data[2]=0xA5A5_0002` and `out_ready=1` → `in_ready=4'b0100`; next cycle `out_valid=1`, `out_data=0xA5A5_0002`, `out_src=2`.
- `in_valid=4'b1111` held and `out_ready=1` for 8 cycles → `out_src` sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Output full, `out_ready=0` for 3 cycles with `in_valid=4'b0011` → `in_ready=0` and `out_data` stable. Raise `out_ready` → requester 1 (`ptr=1`) is accepted in that same cycle.
- `NUM_REQ=3`, all requesters valid → `out_src` 0,1,2,0; `ptr` wraps from 2 to 0, never 3.
- `ARB_LOCK_EN`: requester 1 sends a 3-beat packet (`last` on beat 3) while requester 2 is valid throughout → `out_src` 1,1,1,2.
- Assert `rst_n=0` while `out_valid=1` → `out_valid`, `in_ready`, and `ptr` go to 0 without waiting for a clock edge.
